// File: rtl/jump_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// jump_sequencer_pkg
// Shared constants for the jump sequencer and its link stack:
//   - JPF jump-mode codes
//   - SKIPF condition codes
//   - FSM state encoding
//   - instruction lengths in address units (short = 2, long = 4)
//   - branch_taken(): condition evaluation
// No ports (package).
// -----------------------------------------------------------------------------
package jump_sequencer_pkg;

    // Jump mode (JPF)
    localparam logic [1:0] JPF_JP_RB  = 2'b00;  // PC <- Rb
    localparam logic [1:0] JPF_JP_IND = 2'b01;  // PC <- mem[Rb]
    localparam logic [1:0] JPF_JP_S16 = 2'b10;  // PC <- mem[PC+2]
    localparam logic [1:0] JPF_JR_S16 = 2'b11;  // PC <- PC + signed mem[PC+2]

    // Condition select (SKIPF): bit 1 makes the jump conditional,
    // bit 0 selects the flag polarity that causes the jump.
    localparam logic [1:0] SKIPF_ALWAYS     = 2'b00;
    localparam logic [1:0] SKIPF_ALWAYS_ALT = 2'b01;
    localparam logic [1:0] SKIPF_IF_SET     = 2'b10;
    localparam logic [1:0] SKIPF_IF_CLR     = 2'b11;

    // Instruction lengths
    localparam int INSN_LEN_SHORT = 2;
    localparam int INSN_LEN_LONG  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EVAL   = 2'd1,
        ST_FETCH  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    function automatic logic branch_taken(input logic [1:0] skipf, input logic cc_bit);
        return ~skipf[1] | (cc_bit ^ skipf[0]);
    endfunction

endpackage

// File: rtl/jump_link_stack.sv
// -----------------------------------------------------------------------------
// jump_link_stack
// LIFO of return addresses used by the jump sequencer when built with
// JUMP_LINK_STACK_EN. A push into a full stack and a pop from an empty stack
// are ignored here; the sequencer turns them into its sticky flags.
// Ports:
//   CLK, RESET  clock, asynchronous active-high reset (clears pointer only)
//   push        write data on top of the stack
//   pop         discard the top entry
//   data        value to push
//   top         current top entry (meaningless when empty)
//   full, empty occupancy status
// DEPTH must be a power of two, at least 2.
// -----------------------------------------------------------------------------
module jump_link_stack
    import jump_sequencer_pkg::*;
#(
    parameter int AW    = 16,
    parameter int DEPTH = 8,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] data,
    output logic [AW-1:0] top,
    output logic          full,
    output logic          empty
);

    localparam logic [PW:0] SP_ONE  = (PW+1)'(1);
    localparam logic [PW:0] SP_FULL = (PW+1)'(DEPTH);

    logic [AW-1:0] mem [DEPTH];
    logic [PW:0]   sp;      // number of valid entries
    logic [PW:0]   sp_dec;

    assign full   = (sp == SP_FULL);
    assign empty  = (sp == '0);
    assign sp_dec = sp - SP_ONE;
    assign top    = mem[sp_dec[PW-1:0]];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SP_ONE;
        end else if (pop && !empty) begin
            sp <= sp_dec;
        end
    end

    // Storage carries no reset; only the pointer defines what is valid.
    always_ff @(posedge CLK) begin
        if (push && !full) begin
            mem[sp[PW-1:0]] <= data;
        end
    end

endmodule

// File: rtl/jump_sequencer.sv
// -----------------------------------------------------------------------------
// jump_sequencer
// Executes one jump/call/return instruction per START: evaluates the branch
// condition, optionally fetches the target (or offset) from memory, then
// commits the next PC with a one-cycle PC_LOAD/DONE pulse.
// Build option: define JUMP_LINK_STACK_EN to add a hardware link stack
// (taken JLF pushes the fall-through, taken RETF pops). Without it RETF acts
// as JP Rb and LS_OVF/LS_UNF are tied low.
// Ports:
//   CLK, RESET              clock, asynchronous active-high reset
//   START                   issue strobe (ignored while BUSY)
//   SKIPF, CCF, JPF         condition mode, condition select, jump mode
//   JLF, RETF               link (call) request, return request
//   CC                      condition flags
//   PC, REGB                current instruction address, register B
//   DIN, DIN_VALID          memory read data / acknowledge
//   RD_REQ, ADDR            memory read request / address
//   PC_NEXT, PC_LOAD        next PC and its load strobe
//   LINK_DATA, LINK_WEN     return address and its write strobe
//   BUSY, DONE              instruction in flight / completion pulse
//   LS_OVF, LS_UNF          sticky link-stack overflow / underflow
// -----------------------------------------------------------------------------
module jump_sequencer
    import jump_sequencer_pkg::*;
#(
    parameter int AW       = 16,
    parameter int NCC      = 4,
    parameter int LS_DEPTH = 8,
    localparam int CCW     = (NCC > 1) ? $clog2(NCC) : 1
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           START,
    input  logic [1:0]     SKIPF,
    input  logic [CCW-1:0] CCF,
    input  logic [1:0]     JPF,
    input  logic           JLF,
    input  logic           RETF,
    input  logic [NCC-1:0] CC,
    input  logic [AW-1:0]  PC,
    input  logic [AW-1:0]  REGB,
    input  logic [AW-1:0]  DIN,
    input  logic           DIN_VALID,
    output logic           RD_REQ,
    output logic [AW-1:0]  ADDR,
    output logic [AW-1:0]  PC_NEXT,
    output logic           PC_LOAD,
    output logic [AW-1:0]  LINK_DATA,
    output logic           LINK_WEN,
    output logic           BUSY,
    output logic           DONE,
    output logic           LS_OVF,
    output logic           LS_UNF
);

    state_t state, state_nxt;

    // Latched instruction
    logic [1:0]     skipf_r;
    logic [CCW-1:0] ccf_r;
    logic [1:0]     jpf_r;
    logic           jlf_r;
    logic           retf_r;
    logic [AW-1:0]  pc_r;
    logic [AW-1:0]  regb_r;
    logic           taken_r;

    logic [AW-1:0]  addr_r;
    logic [AW-1:0]  pc_next_r;
    logic [AW-1:0]  link_data_r;

    logic                 taken_now;
    logic                 need_fetch;
    logic [AW-1:0]        insn_len;
    logic [AW-1:0]        fall_through;
    logic [AW-1:0]        ret_target;
    logic [AW-1:0]        eval_target;
    logic [AW-1:0]        fetch_target;
    logic signed [AW-1:0] rel_off;
    logic                 link_commit;
    logic                 ret_commit;

    assign taken_now    = branch_taken(skipf_r, CC[ccf_r]);
    // A return is always a short instruction, whatever JPF says.
    assign insn_len     = (!retf_r && jpf_r[1]) ? AW'(INSN_LEN_LONG) : AW'(INSN_LEN_SHORT);
    assign fall_through = pc_r + insn_len;
    assign need_fetch   = taken_now && !retf_r && (jpf_r != JPF_JP_RB);

    assign rel_off      = $signed(DIN);
    assign fetch_target = (jpf_r == JPF_JR_S16) ? AW'($signed(pc_r) + rel_off) : DIN;

    assign link_commit  = (state == ST_COMMIT) && taken_r && jlf_r && !retf_r;
    assign ret_commit   = (state == ST_COMMIT) && taken_r && retf_r;

`ifdef JUMP_LINK_STACK_EN
    logic [AW-1:0] stk_top;
    logic          stk_full;
    logic          stk_empty;
    logic          ls_ovf_r;
    logic          ls_unf_r;

    jump_link_stack #(
        .AW    (AW),
        .DEPTH (LS_DEPTH)
    ) u_link_stack (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (link_commit),
        .pop   (ret_commit),
        .data  (link_data_r),
        .top   (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // Stack is read during EVAL; the pointer moves only in COMMIT.
    assign ret_target = stk_empty ? fall_through : stk_top;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ls_ovf_r <= 1'b0;
            ls_unf_r <= 1'b0;
        end else begin
            if (link_commit && stk_full) ls_ovf_r <= 1'b1;
            if (ret_commit && stk_empty) ls_unf_r <= 1'b1;
        end
    end

    assign LS_OVF = ls_ovf_r;
    assign LS_UNF = ls_unf_r;
`else
    assign ret_target = regb_r;
    assign LS_OVF     = 1'b0;
    assign LS_UNF     = 1'b0;
`endif

    always_comb begin
        eval_target = regb_r;
        if (!taken_now) begin
            eval_target = fall_through;
        end else if (retf_r) begin
            eval_target = ret_target;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        RD_REQ    = 1'b0;
        PC_LOAD   = 1'b0;
        DONE      = 1'b0;
        BUSY      = 1'b1;
        LINK_WEN  = 1'b0;
        case (state)
            ST_IDLE: begin
                BUSY = 1'b0;
                if (START) state_nxt = ST_EVAL;
            end
            ST_EVAL: begin
                state_nxt = need_fetch ? ST_FETCH : ST_COMMIT;
            end
            ST_FETCH: begin
                RD_REQ = 1'b1;
                if (DIN_VALID) state_nxt = ST_COMMIT;
            end
            ST_COMMIT: begin
                PC_LOAD   = 1'b1;
                DONE      = 1'b1;
                LINK_WEN  = link_commit;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            skipf_r     <= '0;
            ccf_r       <= '0;
            jpf_r       <= '0;
            jlf_r       <= 1'b0;
            retf_r      <= 1'b0;
            pc_r        <= '0;
            regb_r      <= '0;
            taken_r     <= 1'b0;
            addr_r      <= '0;
            pc_next_r   <= '0;
            link_data_r <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        skipf_r <= SKIPF;
                        ccf_r   <= CCF;
                        jpf_r   <= JPF;
                        jlf_r   <= JLF;
                        retf_r  <= RETF;
                        pc_r    <= PC;
                        regb_r  <= REGB;
                    end
                end
                ST_EVAL: begin
                    taken_r     <= taken_now;
                    link_data_r <= fall_through;
                    if (need_fetch) begin
                        // JP (Rb) reads through Rb; the S16 forms read the
                        // immediate word that follows the opcode.
                        addr_r <= (jpf_r == JPF_JP_IND) ? regb_r : pc_r + AW'(INSN_LEN_SHORT);
                    end else begin
                        pc_next_r <= eval_target;
                    end
                end
                ST_FETCH: begin
                    if (DIN_VALID) pc_next_r <= fetch_target;
                end
                default: ;
            endcase
        end
    end

    assign ADDR      = addr_r;
    assign PC_NEXT   = pc_next_r;
    assign LINK_DATA = link_data_r;

endmodule

// File: tb/tb_jump_sequencer.sv
// -----------------------------------------------------------------------------
// tb_jump_sequencer
// Directed bench for jump_sequencer. Each instruction pushes its hand-computed
// commit result into a queue; a monitor pops and compares on every PC_LOAD.
// The issuing task checks latency, memory-request behaviour and pulse width.
// Define JUMP_LINK_STACK_EN to also exercise the link stack boundaries.
// -----------------------------------------------------------------------------
module tb_jump_sequencer;

    localparam int AW  = 16;
    localparam int NCC = 4;
    localparam int CCW = 2;

    logic           CLK = 1'b0;
    logic           RESET = 1'b1;
    logic           START = 1'b0;
    logic [1:0]     SKIPF = '0;
    logic [CCW-1:0] CCF = '0;
    logic [1:0]     JPF = '0;
    logic           JLF = 1'b0;
    logic           RETF = 1'b0;
    logic [NCC-1:0] CC = '0;
    logic [AW-1:0]  PC = '0;
    logic [AW-1:0]  REGB = '0;
    logic [AW-1:0]  DIN = '0;
    logic           DIN_VALID = 1'b0;
    logic           RD_REQ;
    logic [AW-1:0]  ADDR;
    logic [AW-1:0]  PC_NEXT;
    logic           PC_LOAD;
    logic [AW-1:0]  LINK_DATA;
    logic           LINK_WEN;
    logic           BUSY;
    logic           DONE;
    logic           LS_OVF;
    logic           LS_UNF;

    jump_sequencer #(.AW(AW), .NCC(NCC), .LS_DEPTH(8)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .SKIPF(SKIPF), .CCF(CCF),
        .JPF(JPF), .JLF(JLF), .RETF(RETF), .CC(CC), .PC(PC), .REGB(REGB),
        .DIN(DIN), .DIN_VALID(DIN_VALID), .RD_REQ(RD_REQ), .ADDR(ADDR),
        .PC_NEXT(PC_NEXT), .PC_LOAD(PC_LOAD), .LINK_DATA(LINK_DATA),
        .LINK_WEN(LINK_WEN), .BUSY(BUSY), .DONE(DONE), .LS_OVF(LS_OVF),
        .LS_UNF(LS_UNF)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [AW-1:0] pc_next;
        logic          link_wen;
        logic [AW-1:0] link_data;
    } exp_t;

    exp_t          exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            rsp_wait = 0;
    int            rsp_cnt = 0;
    logic [AW-1:0] rsp_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Memory model: acknowledges a read after rsp_wait idle request cycles.
    initial begin
        forever begin
            @(negedge CLK);
            if (DIN_VALID) begin
                DIN_VALID = 1'b0;
                rsp_cnt   = 0;
            end else if (RD_REQ === 1'b1) begin
                if (rsp_cnt == rsp_wait) begin
                    DIN_VALID = 1'b1;
                    DIN       = rsp_data;
                end else begin
                    rsp_cnt++;
                end
            end else begin
                rsp_cnt = 0;
            end
        end
    end

    // Commit monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (PC_LOAD === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_pc_load: got PC_NEXT 0x%0h, expected no commit", PC_NEXT);
                end else begin
                    e = exp_q.pop_front();
                    check("pc_next", 32'(PC_NEXT), 32'(e.pc_next));
                    check("done", 32'(DONE), 32'd1);
                    check("link_wen", 32'(LINK_WEN), 32'(e.link_wen));
                    if (e.link_wen) check("link_data", 32'(LINK_DATA), 32'(e.link_data));
                end
            end
        end
    end

    task automatic exec(input string name,
                        input logic [1:0] skipf, input logic [CCW-1:0] ccf,
                        input logic [NCC-1:0] cc, input logic [1:0] jpf,
                        input logic jlf, input logic retf,
                        input logic [AW-1:0] pc, input logic [AW-1:0] regb,
                        input int waits, input logic [AW-1:0] din,
                        input logic exp_fetch, input logic [AW-1:0] exp_addr,
                        input int exp_lat, input logic [AW-1:0] exp_pcn,
                        input logic exp_lw, input logic [AW-1:0] exp_ld);
        exp_t          e;
        int            cyc;
        logic          rd_seen;
        logic          addr_stable;
        logic          got;
        logic [AW-1:0] addr_first;
        e.pc_next   = exp_pcn;
        e.link_wen  = exp_lw;
        e.link_data = exp_ld;
        exp_q.push_back(e);
        @(negedge CLK);
        SKIPF = skipf; CCF = ccf; CC = cc; JPF = jpf; JLF = jlf; RETF = retf;
        PC = pc; REGB = regb; rsp_wait = waits; rsp_data = din;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        // Changing the sources after issue must not affect the instruction.
        PC = ~pc; REGB = ~regb; JPF = ~jpf; JLF = ~jlf;
        cyc = 0; rd_seen = 1'b0; addr_stable = 1'b1; got = 1'b0; addr_first = '0;
        while (!got && cyc < 40) begin
            @(negedge CLK);
            cyc++;
            if (cyc == 1) check({name, "_busy"}, 32'(BUSY), 32'd1);
            if (RD_REQ === 1'b1) begin
                if (!rd_seen) addr_first = ADDR;
                else if (ADDR !== addr_first) addr_stable = 1'b0;
                rd_seen = 1'b1;
            end
            if (PC_LOAD === 1'b1) got = 1'b1;
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: no PC_LOAD after %0d cycles, expected one", name, cyc);
        end
        check({name, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({name, "_rd_req"}, 32'(rd_seen), 32'(exp_fetch));
        if (exp_fetch) begin
            check({name, "_addr"}, 32'(addr_first), 32'(exp_addr));
            check({name, "_addr_stable"}, 32'(addr_stable), 32'd1);
        end
        @(negedge CLK);
        check({name, "_single_pulse"}, {30'd0, PC_LOAD, BUSY}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) @(negedge CLK);
        check("rst_ctrl", {25'd0, RD_REQ, PC_LOAD, LINK_WEN, BUSY, DONE, LS_OVF, LS_UNF}, 32'd0);
        check("rst_addr", 32'(ADDR), 32'd0);
        check("rst_pc_next", 32'(PC_NEXT), 32'd0);
        check("rst_link_data", 32'(LINK_DATA), 32'd0);
        RESET = 1'b0;

        //    name   skipf ccf  cc      jpf  jlf retf pc        regb      wt din       fetch addr      lat pc_next   lw  link
        exec("jp_rb",  2'b00, 2'd0, 4'b0000, 2'b00, 0, 0, 16'h0100, 16'h1234, 0, 16'h0000, 0, 16'h0000, 2, 16'h1234, 0, 16'h0000);
        exec("jr_z",   2'b10, 2'd0, 4'b0001, 2'b11, 0, 0, 16'h0200, 16'h0000, 3, 16'hFFF0, 1, 16'h0202, 6, 16'h01F0, 0, 16'h0000);
        exec("jp_nt",  2'b11, 2'd0, 4'b0001, 2'b10, 1, 0, 16'h0300, 16'h0000, 0, 16'h0000, 0, 16'h0000, 2, 16'h0304, 0, 16'h0000);
        exec("jp_ind", 2'b01, 2'd1, 4'b0000, 2'b01, 1, 0, 16'h0500, 16'h4000, 0, 16'hBEEF, 1, 16'h4000, 3, 16'hBEEF, 1, 16'h0502);
        exec("jp_s16", 2'b10, 2'd2, 4'b0100, 2'b10, 0, 0, 16'h0600, 16'h0000, 1, 16'h7000, 1, 16'h0602, 4, 16'h7000, 0, 16'h0000);
        exec("jr_wrap",2'b11, 2'd3, 4'b0111, 2'b11, 1, 0, 16'hFFFC, 16'h0000, 0, 16'h0010, 1, 16'hFFFE, 3, 16'h000C, 1, 16'h0000);
        exec("rb_nt",  2'b10, 2'd1, 4'b1101, 2'b00, 1, 0, 16'h0700, 16'h9999, 0, 16'h0000, 0, 16'h0000, 2, 16'h0702, 0, 16'h0000);
`ifdef JUMP_LINK_STACK_EN
        // Top of stack holds the jr_wrap link (0x0000).
        exec("ret",    2'b00, 2'd0, 4'b0000, 2'b10, 1, 1, 16'h0800, 16'h2222, 0, 16'h0000, 0, 16'h0000, 2, 16'h0000, 0, 16'h0000);
`else
        exec("ret",    2'b00, 2'd0, 4'b0000, 2'b10, 1, 1, 16'h0800, 16'h2222, 0, 16'h0000, 0, 16'h0000, 2, 16'h2222, 0, 16'h0000);
`endif
        exec("jr_neg", 2'b00, 2'd0, 4'b0000, 2'b11, 0, 0, 16'h1000, 16'h0000, 2, 16'h8000, 1, 16'h1002, 5, 16'h9000, 0, 16'h0000);

`ifdef JUMP_LINK_STACK_EN
        @(negedge CLK); RESET = 1'b1;
        @(negedge CLK); RESET = 1'b0;
        for (int i = 0; i < 9; i++) begin
            exec("call", 2'b00, 2'd0, 4'b0000, 2'b00, 1, 0, 16'(16'h1000 + i*16), 16'h3000, 0, 16'h0000,
                 0, 16'h0000, 2, 16'h3000, 1, 16'(16'h1000 + i*16 + 2));
            check("ls_ovf_call", 32'(LS_OVF), 32'(i == 8));
        end
        for (int j = 0; j < 9; j++) begin
            exec("pop", 2'b00, 2'd0, 4'b0000, 2'b00, 0, 1, 16'(16'h2000 + j*16), 16'h3333, 0, 16'h0000,
                 0, 16'h0000, 2, (j < 8) ? 16'(16'h1000 + (7-j)*16 + 2) : 16'(16'h2000 + j*16 + 2), 0, 16'h0000);
            check("ls_unf_pop", 32'(LS_UNF), 32'(j == 8));
        end
`endif

        // Reset while waiting on memory
        @(negedge CLK);
        SKIPF = 2'b00; JPF = 2'b01; JLF = 1'b1; RETF = 1'b0; PC = 16'h0900; REGB = 16'h5000;
        rsp_wait = 1000; START = 1'b1;
        @(posedge CLK); #1; START = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_fetch_rd_req", 32'(RD_REQ), 32'd1);
        #2; RESET = 1'b1;
        #1;
        check("rst_fetch_busy", {30'd0, BUSY, RD_REQ}, 32'd0);
        check("rst_fetch_flags", {30'd0, LS_OVF, LS_UNF}, 32'd0);
        @(negedge CLK); RESET = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            check("rst_fetch_no_load", {30'd0, PC_LOAD, BUSY}, 32'd0);
        end
        exec("post_rst", 2'b00, 2'd0, 4'b0000, 2'b00, 0, 0, 16'h0A00, 16'h0ABC, 0, 16'h0000, 0, 16'h0000, 2, 16'h0ABC, 0, 16'h0000);

        repeat (3) @(negedge CLK);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
`ifndef JUMP_LINK_STACK_EN
        check("flags_tied", {30'd0, LS_OVF, LS_UNF}, 32'd0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jump_sequencer.md
JUMP_SEQUENCER -- requirements
Module: jump_sequencer

Interface
REQ-001 SHALL have parameter AW, default 16, address/data width in bits.
REQ-002 SHALL have parameter NCC, default 4, number of condition-code inputs; CCW = clog2(NCC).
REQ-003 SHALL have parameter LS_DEPTH, default 8, link-stack entries (power of two).
REQ-004 Ports: CLK in 1 clock; RESET in 1 asynchronous active-high reset.
REQ-005 Ports: START in 1 issue strobe; SKIPF in 2; CCF in CCW; JPF in 2; JLF in 1 link request; RETF in 1 return request.
REQ-006 Ports: CC in NCC condition flags; PC in AW current instruction address; REGB in AW register-B value.
REQ-007 Ports: DIN in AW memory data; DIN_VALID in 1 memory-read acknowledge.
REQ-008 Ports: RD_REQ out 1; ADDR out AW; PC_NEXT out AW; PC_LOAD out 1; LINK_DATA out AW; LINK_WEN out 1; BUSY out 1; DONE out 1; LS_OVF out 1; LS_UNF out 1.

Function
REQ-009 FSM states SHALL be IDLE, EVAL, FETCH, COMMIT; BUSY high in every state except IDLE.
REQ-010 In IDLE, START SHALL latch all instruction fields, PC, and REGB, then move to EVAL; START is ignored while BUSY.
REQ-011 In EVAL, TAKEN SHALL equal ~SKIPF[1] | (CC[CCF] ^ SKIPF[0]), registered for the rest of the instruction.
REQ-012 Instruction length SHALL be 4 for JPF=10 (JP S16) and JPF=11 (JR S16), and 2 otherwise; fall-through = PC + length, modulo 2^AW.
REQ-013 If TAKEN with JPF=00 (JP Rb), PC_NEXT SHALL be REGB, and EVAL goes to COMMIT.
REQ-014 If TAKEN with JPF=01 (JP (Rb)), EVAL SHALL go to FETCH with ADDR=REGB; PC_NEXT = DIN.
REQ-015 If TAKEN with JPF=10, FETCH SHALL use ADDR=PC+2; PC_NEXT = DIN.
REQ-016 If TAKEN with JPF=11, FETCH SHALL use ADDR=PC+2; PC_NEXT = PC + DIN, modulo 2^AW, with DIN treated as signed.
REQ-017 Not-taken instructions SHALL go from EVAL to COMMIT with PC_NEXT = fall-through, and SHALL never assert RD_REQ.
REQ-018 In FETCH, RD_REQ and ADDR SHALL stay stable until DIN_VALID; DIN is captured on the DIN_VALID cycle, and the FSM then goes to COMMIT. There is no timeout.
REQ-019 COMMIT SHALL pulse PC_LOAD and DONE for exactly one cycle, then return to IDLE.
REQ-020 Minimum latency SHALL be START to PC_LOAD = 2 cycles without a fetch, and 3 + (wait cycles) with a fetch.
REQ-021 If TAKEN and JLF=1, COMMIT SHALL assert LINK_WEN with LINK_DATA = fall-through; if not taken, LINK_WEN stays 0.
REQ-022 RETF=1 SHALL override JPF/JLF; the return's length is 2.

Reset
REQ-023 RESET SHALL force IDLE; RD_REQ, PC_LOAD, LINK_WEN, BUSY, DONE, LS_OVF, LS_UNF = 0; ADDR, PC_NEXT, LINK_DATA = 0; stack pointer = 0.
REQ-024 RESET asserted mid-instruction SHALL abandon the instruction with no PC_LOAD and no stack change.

Configuration
REQ-025 Macro JUMP_LINK_STACK_EN SHALL compile in a LS_DEPTH-entry hardware link stack.
REQ-026 With the macro: a taken JLF pushes the fall-through in COMMIT, and a taken RETF pops, with PC_NEXT = popped value.
REQ-027 With the macro, stack boundaries: a push when full is discarded and sets sticky LS_OVF; a pop when empty sets sticky LS_UNF and gives PC_NEXT = fall-through. Both flags clear only on RESET.
REQ-028 Without the macro, RETF SHALL behave as JP Rb, and LS_OVF/LS_UNF SHALL be tied 0.

Structure
REQ-029 The shared constants package SHALL hold the JPF mode codes, SKIPF codes, FSM state encoding, and the instruction-length constants 2/4.
REQ-030 The link stack SHALL be one sub-module, jump_link_stack (push, pop, data, full, empty), instantiated only under JUMP_LINK_STACK_EN.

Verification
REQ-031 JP Rb, SKIPF=00, REGB=0x1234, PC=0x0100 -> PC_LOAD 2 cycles after START, PC_NEXT=0x1234.
REQ-032 JR, SKIPF=10, CCF=Z, CC[0]=1, PC=0x0200, DIN=0xFFF0 after 3 wait cycles -> RD_REQ held with ADDR=0x0202, PC_NEXT=0x01F0.
REQ-033 JP S16, SKIPF=11, CC[Z]=1 (not taken), PC=0x0300 -> no RD_REQ, PC_NEXT=0x0304, LINK_WEN=0 even with JLF=1.
REQ-034 With the macro: 9 linked JP Rb calls at LS_DEPTH=8, then 9 RETF -> LS_OVF=1 after the 9th call; pops return the 8 stored links in LIFO order; the 9th RETF sets LS_UNF with PC_NEXT=PC+2.
REQ-035 RESET pulse during FETCH -> IDLE next cycle, BUSY=0, no PC_LOAD; a following START executes normally.
